// File: rtl/cos_scheduler.sv
// Round-robin arbiter that shares one iterative cosine unit between N_REQ clients.
// It grants one request at a time, launches the unit, and returns the result tagged with the client index.
module cos_scheduler #(
    parameter int N_REQ = 4,
    parameter int X_W   = 10,
    parameter int Y_W   = 8,
    parameter int R_W   = 10,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [R_W-1:0]         res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic                   cos_start,
    output logic [X_W-1:0]         cos_x,
    output logic [Y_W-1:0]         cos_y,
    input  logic                   cos_ready,
    input  logic [R_W-1:0]         cos_result
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        GUARD,
        WAIT,
        DELIVER
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] id;
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    int              idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] i);
        logic [N_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Search starts just above the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = GUARD;
            // The unit may still show ready from the previous job while it samples start.
            GUARD:   state_nxt = WAIT;
            WAIT:    if (cos_ready) state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            done      <= '0;
            cos_start <= 1'b0;
            busy      <= 1'b0;
            cos_x     <= '0;
            cos_y     <= '0;
            res_data  <= '0;
            res_id    <= '0;
            id        <= '0;
            last      <= ID_W'(N_REQ - 1);
        end else begin
            grant     <= '0;
            done      <= '0;
            cos_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= onehot(pick_id);
                        cos_x <= req_x[int'(pick_id)*X_W +: X_W];
                        cos_y <= req_y[int'(pick_id)*Y_W +: Y_W];
                        id    <= pick_id;
                        last  <= pick_id;
                        busy  <= 1'b1;
                    end
                end
                LAUNCH: cos_start <= 1'b1;
                GUARD: ;
                WAIT: begin
                    if (cos_ready) begin
                        res_data <= cos_result;
                        res_id   <= id;
                        done     <= onehot(id);
                    end
                end
                // The done pulse is visible in this cycle; busy drops for the following idle cycle.
                DELIVER: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_scheduler.sv
// Directed testbench for cos_scheduler with a behavioural cosine-unit stub.
// The stub holds ready for one cycle after start, then raises it again stub_lat cycles later.
module tb_cos_scheduler;
    localparam int N_REQ = 4;
    localparam int X_W   = 10;
    localparam int Y_W   = 8;
    localparam int R_W   = 10;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*X_W-1:0] req_x;
    logic [N_REQ*Y_W-1:0] req_y;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic [R_W-1:0]       res_data;
    logic [ID_W-1:0]      res_id;
    logic                 busy;
    logic                 cos_start;
    logic [X_W-1:0]       cos_x;
    logic [Y_W-1:0]       cos_y;
    logic                 cos_ready;
    logic [R_W-1:0]       cos_result;

    int errors = 0;
    int checks = 0;

    int             stub_lat = 20;
    logic           use_sum  = 1'b0;
    logic [R_W-1:0] stub_res = 10'd700;
    logic [R_W-1:0] stub_val;

    always #5 clk = ~clk;

    cos_scheduler #(
        .N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .grant(grant), .done(done), .res_data(res_data), .res_id(res_id),
        .busy(busy), .cos_start(cos_start), .cos_x(cos_x), .cos_y(cos_y),
        .cos_ready(cos_ready), .cos_result(cos_result)
    );

    // Cosine unit stub: result is either a fixed value or cos_x + cos_y sampled at start.
    initial begin
        cos_ready  = 1'b1;
        cos_result = '0;
        stub_val   = '0;
        forever begin
            @(negedge clk);
            if (cos_start && !rst) begin
                stub_val = use_sum ? (R_W'(cos_x) + R_W'(cos_y)) : stub_res;
                @(negedge clk);
                cos_ready = 1'b0;
                for (int k = 0; k < stub_lat; k++) begin
                    if (!busy) break;
                    @(negedge clk);
                end
                cos_result = stub_val;
                cos_ready  = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion before 200000");
        $fatal(1, "timeout");
    end

    task automatic set_op(input int s, input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        req_x[s*X_W +: X_W] = x;
        req_y[s*Y_W +: Y_W] = y;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        req   = '0;
        req_x = '0;
        req_y = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, done, busy, cos_start} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {grant, done, busy, cos_start});
        end
        checks++;
        if ({cos_x, cos_y, res_data, res_id} !== 30'b0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {cos_x, cos_y, res_data, res_id});
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        int n;
        use_sum  = 1'b0;
        stub_res = 10'd700;
        stub_lat = 20;
        set_op(0, 10'b0100000000, 8'd1);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b busy=%b required 0001/1", grant, busy);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (cos_start !== 1'b1 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_start: got start=%b grant=%b required 1/0000", cos_start, grant);
        end
        checks++;
        if (cos_x !== 10'd256 || cos_y !== 8'd1) begin
            errors++;
            $display("FAIL single_operands: got x=%0d y=%0d required 256/1", cos_x, cos_y);
        end
        n = 0;
        while (done === 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 22) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles start-to-done required 22", n);
        end
        checks++;
        if (done !== 4'b0001 || res_data !== 10'd700 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL single_done: got done=%b data=%0d id=%0d required 0001/700/0", done, res_data, res_id);
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || res_data !== 10'd700) begin
            errors++;
            $display("FAIL single_after: got done=%b busy=%b data=%0d required 0000/0/700", done, busy, res_data);
        end
    endtask

    task automatic test_round_robin;
        int             n;
        int             s;
        int             order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]     e;
        logic [R_W-1:0] r;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        use_sum  = 1'b1;
        stub_lat = 3;
        for (int i = 0; i < N_REQ; i++) set_op(i, X_W'(16 * (i + 1)), Y_W'(i + 1));
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            s = order[j];
            e = 4'b0001 << s;
            r = R_W'(17 * (s + 1));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (grant === 4'b0000 && n < 50);
            checks++;
            if (grant !== e) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b required %b", j, grant, e);
            end
            req[s] = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done === 4'b0000 && n < 50);
            checks++;
            if (done !== e || res_id !== ID_W'(s) || res_data !== r) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%b id=%0d data=%0d required %b/%0d/%0d", j, done, res_id, res_data, e, s, r);
            end
            req[s] = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap%0d: got busy=%b grant=%b required 0/0000", j, busy, grant);
            end
        end
        req = '0;
    endtask

    task automatic test_pointer_wrap;
        int         n;
        int         s;
        int         order [3] = '{2, 0, 2};
        logic [3:0] e;
        stub_lat = 2;
        req      = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            s = order[j];
            e = 4'b0001 << s;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (grant === 4'b0000 && n < 50);
            checks++;
            if (grant !== e) begin
                errors++;
                $display("FAIL wrap_grant%0d: got %b required %b", j, grant, e);
            end
            req[s] = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done === 4'b0000 && n < 50);
            if (j == 0) req = 4'b0101;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_operand_stability;
        int   n;
        logic moved;
        use_sum  = 1'b1;
        stub_lat = 10;
        set_op(1, 10'd300, 8'd5);
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant === 4'b0000 && n < 50);
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL stab_grant: got %b required 0010", grant);
        end
        req = '0;
        @(negedge clk);
        set_op(1, 10'b0010100100, 8'd99);
        moved = 1'b0;
        n = 0;
        while (done === 4'b0000 && n < 100) begin
            if (cos_x !== 10'd300 || cos_y !== 8'd5) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL stab_hold: got operand change during job=%b required 0", moved);
        end
        checks++;
        if (done !== 4'b0010 || cos_x !== 10'd300 || res_data !== 10'd305) begin
            errors++;
            $display("FAIL stab_done: got done=%b x=%0d data=%0d required 0010/300/305", done, cos_x, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_guard;
        int   n;
        logic early;
        use_sum  = 1'b0;
        stub_res = 10'd123;
        stub_lat = 5;
        req      = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant === 4'b0000 && n < 50);
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL guard_grant: got %b required 1000", grant);
        end
        req = '0;
        @(negedge clk);
        early = 1'b0;
        n = 0;
        while (done === 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n < 7) early = 1'b1;
        checks++;
        if (early !== 1'b0 || n != 7) begin
            errors++;
            $display("FAIL guard_latency: got %0d cycles start-to-done required 7", n);
        end
        checks++;
        if (done !== 4'b1000 || res_id !== 2'd3 || res_data !== 10'd123) begin
            errors++;
            $display("FAIL guard_done: got done=%b id=%0d data=%0d required 1000/3/123", done, res_id, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int   n;
        logic seen;
        use_sum  = 1'b1;
        stub_lat = 30;
        set_op(0, 10'd40, 8'd2);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant === 4'b0000 && n < 50);
        req = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({grant, done, busy, cos_start, cos_x, cos_y, res_data, res_id} !== 40'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h required 0", {grant, done, busy, cos_start, cos_x, cos_y, res_data, res_id});
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone: got activity after reset=%b required 0", seen);
        end
        stub_lat = 2;
        set_op(1, 10'd50, 8'd3);
        req = 4'b0011;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant === 4'b0000 && n < 50);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_prio: got %b required 0001", grant);
        end
        req[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === 4'b0000 && n < 50);
        checks++;
        if (res_id !== 2'd0 || res_data !== 10'd42) begin
            errors++;
            $display("FAIL mid_job0: got id=%0d data=%0d required 0/42", res_id, res_data);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant === 4'b0000 && n < 50);
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL mid_next: got %b required 0010", grant);
        end
        req = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === 4'b0000 && n < 50);
        checks++;
        if (done !== 4'b0010 || res_id !== 2'd1 || res_data !== 10'd53) begin
            errors++;
            $display("FAIL mid_job1: got done=%b id=%0d data=%0d required 0010/1/53", done, res_id, res_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_operand_stability();
        test_guard();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
